// File: rtl/unified_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and constants for the unified byte-wide memory arbiter.
//   arb_state_t    : transfer FSM states (IDLE, XFER, LAST, RESP)
//   OWNER_IF/DM    : encoding of which requester owns the current transfer
//   BYTES_PER_WORD : beats per 32-bit access
//   word_byte()    : little-endian byte lane extraction from a 32-bit word
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    LAST = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam int BYTES_PER_WORD = 4;

  // Byte idx of a word, little-endian: idx 0 is bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bundles the fetch port, the data-stage port and the byte-wide memory port.
//   slave  : arbiter view (takes requests and mem_rdata, drives responses and
//            the memory beat signals)
//   master : environment view (requesters plus the memory itself)
// -----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 8
) ();

  // Instruction fetch (read-only)
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;

  // Data stage (read/write)
  logic              dm_req;
  logic              dm_we;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_done;

  // Byte-wide synchronous-read memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/unified_mem_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Chooses which requester gets the memory when the arbiter is idle and keeps
// the data-stage streak counter that stops fetch from starving.
//   clk, reset : clock and synchronous active-high reset
//   pick_en    : arbiter is idle and may grant this cycle
//   if_req     : fetch request
//   dm_req     : data-stage request
//   gnt_valid  : a grant happens this cycle
//   gnt_owner  : OWNER_IF or OWNER_DM (meaningful with gnt_valid)
// -----------------------------------------------------------------------------
module arb_pick
  import mips_mem_pkg::*;
#(
  parameter int MAX_DM_STREAK = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pick_en,
  input  logic if_req,
  input  logic dm_req,
  output logic gnt_valid,
  output logic gnt_owner
);

  localparam int SW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  always_comb begin
    gnt_valid = pick_en & (if_req | dm_req);
    // Data stage normally wins a tie; once it has won MAX_DM_STREAK times
    // in a row, fetch gets the next tie.
    if (if_req && dm_req) begin
      gnt_owner = (streak_q == STREAK_MAX) ? OWNER_IF : OWNER_DM;
    end else begin
      gnt_owner = dm_req ? OWNER_DM : OWNER_IF;
    end

    streak_d = streak_q;
    if (gnt_valid) begin
      if (gnt_owner == OWNER_DM) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one byte-wide synchronous-read memory between instruction fetch and
// the data stage. Each 32-bit access is serialised into four little-endian
// byte beats; the owner receives a one-cycle done pulse.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave modport of unified_mem_arbiter_if (fetch, data, memory)
//   busy  : a transfer is in progress (FSM not idle)
// Timing: request seen in idle cycle t -> beats t+1..t+4 -> byte 3 captured
// in t+5 -> done in t+6 -> idle again in t+7.
// -----------------------------------------------------------------------------
module unified_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int MAX_DM_STREAK = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus,
  output logic                  busy
);

  arb_state_t        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       rbuf_q, rbuf_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic gnt_valid, gnt_owner;

  // Requester addresses wider than the memory are truncated on purpose.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.if_addr[31:ADDR_W], bus.dm_addr[31:ADDR_W]};

  arb_pick #(
    .MAX_DM_STREAK (MAX_DM_STREAK)
  ) u_pick (
    .clk       (clk),
    .reset     (reset),
    .pick_en   (state_q == IDLE),
    .if_req    (bus.if_req),
    .dm_req    (bus.dm_req),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_owner;
          if (gnt_owner == OWNER_DM) begin
            addr_d  = bus.dm_addr[ADDR_W-1:0];
            we_d    = bus.dm_we;
            wdata_d = bus.dm_wdata;
          end else begin
            addr_d  = bus.if_addr[ADDR_W-1:0];
            we_d    = 1'b0;
            wdata_d = '0;
          end
          state_d     = XFER;
          beat_d      = 2'd0;
          // Beat outputs are registered, so beat 0 is set up here.
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = word_byte(wdata_d, 2'd0);
        end
      end

      XFER: begin
        // Read data lags its beat by one cycle: beat b-1's byte arrives now.
        if (beat_q != 2'd0) begin
          rbuf_d[{beat_q - 2'd1, 3'b000} +: 8] = bus.mem_rdata;
        end
        if (beat_q == 2'd3) begin
          state_d = LAST;
        end else begin
          beat_d      = beat_q + 2'd1;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + ADDR_W'(beat_d);
          mem_wdata_d = word_byte(wdata_q, beat_d);
        end
      end

      LAST: begin
        state_d = RESP;
        // Commit the whole word at once so the owner's rdata never shows a
        // partially assembled value.
        if (!we_q) begin
          if (owner_q == OWNER_DM) begin
            dm_rdata_d = {bus.mem_rdata, rbuf_q};
          end else begin
            if_rdata_d = {bus.mem_rdata, rbuf_q};
          end
        end
        if (owner_q == OWNER_DM) begin
          dm_done_d = 1'b1;
        end else begin
          if_done_d = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      owner_q     <= OWNER_IF;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != IDLE);

endmodule
